// File: rtl/nios_system_cpu_mul_seq.sv
// nios_system_cpu_mul_seq
//
// Two-pass sequencer in front of the CPU multiply cell. The cell multiplies a
// 32-bit source by a 16-bit source, so a 32x32 request is split into a pass on
// the low half of the multiplier and a pass on the high half. The low 32 bits
// of the product are r0 + (r1 << 16), where r0 = a*b_lo and r1 = a*b_hi.
//
// Ports:
//   clk, reset_n        single clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_src1 = a, in_src2 = b
//   out_valid/out_ready result handshake; out_result = (a*b) mod 2^32
//   busy                high whenever the sequencer is not idle
//   A_mul_src1/2        sources driven to the multiply cell
//   A_mul_cell_result   cell result, valid one cycle after sources are driven
//
// Configuration:
//   NIOS_MUL_SEQ_ZERO_BYPASS_EN  when defined, a request with a zero operand
//                                skips both passes and completes with 0.

module nios_system_cpu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] r0_q;
  logic        accept;
  logic [31:0] pass1_shifted;

  assign accept = (state_q == IDLE) && in_valid;

  // Only the low 16 bits of the high-half pass survive the shift into the
  // upper product half; the rest falls off the 32-bit result.
  assign pass1_shifted = A_mul_cell_result << 16;

`ifdef NIOS_MUL_SEQ_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (in_src1 == 32'h0) || (in_src2 == 32'h0);
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef NIOS_MUL_SEQ_ZERO_BYPASS_EN
          if (zero_op) state_d = DONE;
          else         state_d = P0;
`else
          state_d = P0;
`endif
        end
      end
      P0:      state_d = P1;
      P1:      state_d = FIN;
      FIN:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cell sources: the multiplier half for the current pass, zero otherwise so
  // the cell sees a quiet bus when no pass is in flight.
  always_comb begin
    A_mul_src1 = 32'h0;
    A_mul_src2 = 32'h0;
    case (state_q)
      P0: begin
        A_mul_src1 = a_q;
        A_mul_src2 = {16'h0, b_q[15:0]};
      end
      P1: begin
        A_mul_src1 = a_q;
        A_mul_src2 = {16'h0, b_q[31:16]};
      end
      default: begin
        A_mul_src1 = 32'h0;
        A_mul_src2 = 32'h0;
      end
    endcase
  end

  // Datapath: operand latch on accept, low-pass capture in P1 (the cell result
  // for P0's sources is valid then), and the final combine in FIN. out_result
  // is only written in FIN (or on a bypass accept), so it holds through DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      r0_q       <= 32'h0;
      out_result <= 32'h0;
    end else begin
      if (accept) begin
        a_q <= in_src1;
        b_q <= in_src2;
`ifdef NIOS_MUL_SEQ_ZERO_BYPASS_EN
        if (zero_op) out_result <= 32'h0;
`endif
      end
      if (state_q == P1) begin
        r0_q <= A_mul_cell_result;
      end
      if (state_q == FIN) begin
        out_result <= r0_q + pass1_shifted;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_nios_system_cpu_mul_seq.sv
// tb_nios_system_cpu_mul_seq
//
// Directed bench for the multiply sequencer. A behavioural model of the
// multiply cell (registered 32x16 multiply, cleared by reset_n) sits on the
// cell ports. A vector table covers the main arithmetic cases; hand-written
// sequences cover backpressure, reset during P1 and the zero-operand path.

module tb_nios_system_cpu_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;
  logic [31:0] A_mul_src1;
  logic [31:0] A_mul_src2;
  logic [31:0] A_mul_cell_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
    string       name;
  } vec_t;

  vec_t vecs[8];

  nios_system_cpu_mul_seq dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_src1           (in_src1),
    .in_src2           (in_src2),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .busy              (busy),
    .A_mul_src1        (A_mul_src1),
    .A_mul_src2        (A_mul_src2),
    .A_mul_cell_result (A_mul_cell_result)
  );

  // Clock: 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiply cell model: result one cycle after sources, aclr on reset_n
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) A_mul_cell_result <= 32'h0;
    else          A_mul_cell_result <= A_mul_src1 * {16'h0, A_mul_src2[15:0]};
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
    end
  endtask

  // Present a request at a negedge and hold it through the accept edge. Leaves
  // time at 1 ns after the accept edge, with the inputs scrambled so a design
  // that fails to latch its operands gives the wrong answer.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_src1  = a;
    in_src2  = b;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_src1  = $urandom;
    in_src2  = $urandom;
  endtask

  // Wait for out_valid counting cycles after the accept edge (starting from
  // startCyc), check latency and value, then complete the handshake.
  task automatic waitResult(input logic [31:0] expected, input int expLat,
                            input int startCyc, input string name);
    int  cyc;
    bit  seen;
    seen = 1'b0;
    cyc  = startCyc;
    while (!seen && cyc <= 20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else           cyc++;
    end
    checkOutput({name, "_seen"}, {31'h0, seen}, 32'h1);
    if (seen) begin
      checkOutput({name, "_latency"}, cyc, expLat);
      checkOutput({name, "_result"}, out_result, expected);
      checkOutput({name, "_in_ready_low"}, {31'h0, in_ready}, 32'h0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({name, "_valid_dropped"}, {31'h0, out_valid}, 32'h0);
    end
  endtask

  function automatic int expectedLatency(input logic [31:0] a, input logic [31:0] b);
`ifdef NIOS_MUL_SEQ_ZERO_BYPASS_EN
    if (a == 32'h0 || b == 32'h0) return 1;
`endif
    return 4;
  endfunction

  initial begin
    logic [31:0] held;
    bit          sawValid;

    vecs[0] = '{32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "basic"};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "all_ones"};
    vecs[2] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, "low_ones"};
    vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "wrap_zero"};
    vecs[4] = '{32'h0000_0007, 32'h0000_0009, 32'h0000_003F, "small"};
    vecs[5] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0000, "carry_out"};
    vecs[6] = '{32'h0001_2345, 32'h0001_0000, 32'h2345_0000, "high_pass"};
    vecs[7] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F, "three_five"};

    in_valid  = 1'b0;
    in_src1   = 32'h0;
    in_src2   = 32'h0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    checkOutput("rst_in_ready",   {31'h0, in_ready},  32'h1);
    checkOutput("rst_busy",       {31'h0, busy},      32'h0);
    checkOutput("rst_out_valid",  {31'h0, out_valid}, 32'h0);
    checkOutput("rst_out_result", out_result,         32'h0);
    checkOutput("rst_src1",       A_mul_src1,         32'h0);
    checkOutput("rst_src2",       A_mul_src2,         32'h0);
    reset_n = 1'b1;

    // Table-driven arithmetic vectors
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].name, "_busy"}, {31'h0, busy}, 32'h1);
      waitResult(vecs[i].expected, expectedLatency(vecs[i].a, vecs[i].b), 1, vecs[i].name);
    end

    // Backpressure: hold out_ready low for 10 cycles with a new request pending
    applyStimulus(32'h0001_0003, 32'h0002_0005);
    sawValid = 1'b0;
    for (int c = 0; c < 20 && !sawValid; c++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("bp_valid_seen", {31'h0, sawValid}, 32'h1);
    held     = out_result;
    checkOutput("bp_result", held, 32'h000B_000F);
    in_src1  = 32'h3;
    in_src2  = 32'h5;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("bp_valid_held",  {31'h0, out_valid}, 32'h1);
      checkOutput("bp_result_held", out_result,         held);
      checkOutput("bp_in_ready",    {31'h0, in_ready},  32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    // Handshake edge done: now IDLE, pending request not yet taken
    checkOutput("bp_idle_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("bp_idle_busy",     {31'h0, busy},     32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_src1  = 32'hDEAD_BEEF;
    in_src2  = 32'hCAFE_F00D;
    checkOutput("bp_accepted_busy", {31'h0, busy}, 32'h1);
    waitResult(32'h0000_000F, 4, 1, "bp_next");

    // Reset asserted during P1
    applyStimulus(32'h0001_2345, 32'h0002_0003);
    @(posedge clk);
    #1;
    checkOutput("p1_src2_high", A_mul_src2, 32'h0000_0002);
    reset_n = 1'b0;
    #1;
    checkOutput("p1rst_in_ready",   {31'h0, in_ready},  32'h1);
    checkOutput("p1rst_busy",       {31'h0, busy},      32'h0);
    checkOutput("p1rst_out_valid",  {31'h0, out_valid}, 32'h0);
    checkOutput("p1rst_out_result", out_result,         32'h0);
    checkOutput("p1rst_src1",       A_mul_src1,         32'h0);
    checkOutput("p1rst_src2",       A_mul_src2,         32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    sawValid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("p1rst_no_valid", {31'h0, sawValid}, 32'h0);
    applyStimulus(32'h3, 32'h5);
    waitResult(32'h0000_000F, 4, 1, "after_rst");

    // Zero operand
    applyStimulus(32'h0, 32'h0000_1234);
`ifdef NIOS_MUL_SEQ_ZERO_BYPASS_EN
    checkOutput("zero_src2_quiet", A_mul_src2, 32'h0);
    waitResult(32'h0, 1, 1, "zero_op");
`else
    @(negedge clk);
    checkOutput("zero_src2_p0", A_mul_src2, 32'h0000_1234);
    checkOutput("zero_src1_p0", A_mul_src1, 32'h0);
    @(negedge clk);
    checkOutput("zero_src2_p1", A_mul_src2, 32'h0);
    waitResult(32'h0, 4, 3, "zero_op");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
